serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder, one bit per clock, LSB first. Each bit goes through
//  one instance of the existing fulladder cell. A carry flip-flop feeds each bit's

---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/serial_adder_if.sv | 21 ++
 rtl/serial_adder_fulladder.sv | 11 +
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

   // Encoding 2'd3 is never entered; the FSM treats it as IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder plus a debug view of the FSM state.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
);
   // start is sampled on clk and accepted only in IDLE or DONE; a/b/cin matter only on
   // that edge. done pulses for one cycle, and sum/cout hold until the next result lands.
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   state_t           dbg_state;

   modport master (output start, a, b, cin, input busy, done, sum, cout, dbg_state);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, dbg_state);
endinterface

// File: rtl/serial_adder_fulladder.sv
// One-bit full adder slice used by the serial adder.
module serial_adder_fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, through a single full-adder
// slice with the carry fed back through a flip-flop.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   serial_adder_if.slave  bus
);
   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic             w_load;
   logic             w_step;
   logic             w_last;
   logic [WIDTH-1:0] r_sh_a;
   logic [WIDTH-1:0] r_sh_b;
   logic [WIDTH-1:0] r_sh_s;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             w_s;
   logic             w_co;

   serial_adder_fulladder u_fa (
      .a    (r_sh_a[0]),
      .b    (r_sh_b[0]),
      .cin  (r_carry),
      .sum  (w_s),
      .cout (w_co)
   );

   assign w_last = (r_cnt == LAST_BIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_load       = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (w_last) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            if (bus.start) begin
               w_load       = 1'b1;
               w_state_next = ST_RUN;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Result registers move only on the final bit, so sum/cout never ripple during RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh_a  <= '0;
         r_sh_b  <= '0;
         r_sh_s  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else if (w_load) begin
         r_sh_a  <= bus.a;
         r_sh_b  <= bus.b;
         r_sh_s  <= '0;
         r_carry <= bus.cin;
         r_cnt   <= '0;
      end else if (w_step) begin
         r_sh_a  <= r_sh_a >> 1;
         r_sh_b  <= r_sh_b >> 1;
         r_sh_s  <= {w_s, r_sh_s[WIDTH-1:1]};
         r_carry <= w_co;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            r_sum  <= {w_s, r_sh_s[WIDTH-1:1]};
            r_cout <= w_co;
         end
      end
   end

   assign bus.busy      = (r_state == ST_RUN);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases and random adds at WIDTH=8,
// plus an exhaustive sweep of a WIDTH=4 instance.
module tb_serial_adder;
   import serial_adder_pkg::*;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   logic [8:0] last8;
   logic [8:0] exp_q[$];

   serial_adder_if #(.WIDTH(8)) b8 ();
   serial_adder_if #(.WIDTH(4)) b4 ();

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));
   serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One WIDTH=8 add; optionally pokes start with a=8'h11 partway through RUN.
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input bit poke);
      logic [8:0] exp;
      int cyc;
      int busy_n;
      bit seen;
      exp = 9'(ta) + 9'(tb_v) + 9'(tc);
      b8.start = 1'b1;
      b8.a     = ta;
      b8.b     = tb_v;
      b8.cin   = tc;
      tick();
      b8.start = 1'b0;
      b8.a     = 8'($urandom);
      b8.b     = 8'($urandom);
      b8.cin   = 1'($urandom);
      cyc    = 1;
      busy_n = 0;
      seen   = 1'b0;
      while (!seen && cyc <= 20) begin
         if (b8.done) begin
            seen = 1'b1;
         end else begin
            if (b8.busy) busy_n++;
            check("hold_during_run", {b8.cout, b8.sum}, last8);
            if (poke && cyc == 3) begin
               b8.start = 1'b1;
               b8.a     = 8'h11;
            end else begin
               b8.start = 1'b0;
            end
            tick();
            cyc++;
         end
      end
      check("done_seen", seen, 1);
      check("latency", cyc, 9);
      check("busy_cycles", busy_n, 8);
      check("busy_at_done", b8.busy, 0);
      check("result8", {b8.cout, b8.sum}, exp);
      last8 = exp;
      tick();
      check("done_one_cycle", b8.done, 0);
      check("state_idle_after", b8.dbg_state, ST_IDLE);
   endtask

   task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
      logic [4:0] exp;
      int cyc;
      exp = 5'(ta) + 5'(tb_v) + 5'(tc);
      b4.start = 1'b1;
      b4.a     = ta;
      b4.b     = tb_v;
      b4.cin   = tc;
      tick();
      b4.start = 1'b0;
      cyc = 1;
      while (!b4.done && cyc <= 12) begin
         tick();
         cyc++;
      end
      check("latency4", cyc, 5);
      check("result4", {b4.cout, b4.sum}, exp);
   endtask

   initial begin
      int gap;
      int pulses;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic [8:0] hold;
      n_vec = 0;
      n_err = 0;
      last8 = '0;
      reset = 1'b1;
      b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
      b4.start = 1'b0; b4.a = '0; b4.b = '0; b4.cin = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // reset state
      check("rst_sum", b8.sum, 0);
      check("rst_cout", b8.cout, 0);
      check("rst_busy", b8.busy, 0);
      check("rst_done", b8.done, 0);
      check("rst_state", b8.dbg_state, ST_IDLE);
      tick();

      // directed
      run8(8'h00, 8'h00, 1'b0, 1'b0);
      run8(8'hFF, 8'h01, 1'b0, 1'b0);
      run8(8'hA5, 8'h5A, 1'b1, 1'b0);
      run8(8'hFF, 8'hFF, 1'b1, 1'b0);
      run8(8'h12, 8'h34, 1'b0, 1'b1);

      // reset partway through RUN abandons the add without a done pulse
      b8.start = 1'b1; b8.a = 8'h77; b8.b = 8'h99; b8.cin = 1'b1;
      tick();
      b8.start = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      #1;
      check("arst_sum", b8.sum, 0);
      check("arst_cout", b8.cout, 0);
      check("arst_busy", b8.busy, 0);
      check("arst_done", b8.done, 0);
      check("arst_state", b8.dbg_state, ST_IDLE);
      @(negedge clk);
      reset = 1'b0;
      last8 = '0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (b8.done) pulses++;
         tick();
      end
      check("no_done_after_reset", pulses, 0);
      run8(8'h3C, 8'h0F, 1'b1, 1'b0);

      // back-to-back with start held high across DONE
      b8.start = 1'b1;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      b8.a = ra; b8.b = rb; b8.cin = rc;
      exp_q.push_back(9'(ra) + 9'(rb) + 9'(rc));
      tick();
      for (int k = 0; k < 5; k++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         b8.a = ra; b8.b = rb; b8.cin = rc;
         if (k < 4) exp_q.push_back(9'(ra) + 9'(rb) + 9'(rc));
         else b8.start = 1'b0;
         hold = {b8.cout, b8.sum};
         gap = 1;
         while (!b8.done && gap <= 20) begin
            check("b2b_hold", {b8.cout, b8.sum}, hold);
            tick();
            gap++;
         end
         check("b2b_period", gap, 9);
         if (exp_q.size() > 0) check("b2b_result", {b8.cout, b8.sum}, exp_q.pop_front());
         last8 = {b8.cout, b8.sum};
         tick();
      end
      check("b2b_queue_empty", exp_q.size(), 0);
      tick();

      // random adds
      for (int k = 0; k < 20; k++) begin
         run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      end

      // WIDTH=4 exhaustive
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++)
               run4(4'(ia), 4'(ib), 1'(ic));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
